// File: rtl/cov_mean_axil_regs.sv
// AXI4-Lite slave register file for the Cov_Mean coprocessor, with per-register write pulses.
// Define COV_MEAN_AXIL_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module cov_mean_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IDX_W = AW - 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef COV_MEAN_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_beat_t;

  // State
  logic             aw_held_q, aw_held_d;
  logic [IDX_W-1:0] aw_idx_q,  aw_idx_d;
  logic             w_held_q,  w_held_d;
  wr_beat_t         w_beat_q,  w_beat_d;
  logic             bvalid_q,  bvalid_d;
  logic [1:0]       bresp_q,   bresp_d;
  logic             rvalid_q,  rvalid_d;
  logic [DW-1:0]    rdata_q,   rdata_d;
  logic [1:0]       rresp_q,   rresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];

  // Combinational helpers
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  wr_beat_t         wr_beat;
  logic             wr_mapped, rd_mapped;
  logic [DW-1:0]    rd_word;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready signals drop the instant reset is asserted.
  always_comb begin : p_ready
    S_AXI_AWREADY = ~aw_held_q & ~bvalid_q & ~ARESET;
    S_AXI_WREADY  = ~w_held_q  & ~bvalid_q & ~ARESET;
    S_AXI_ARREADY = ~rvalid_q  & ~ARESET;
  end

  always_comb begin : p_outputs
    S_AXI_BVALID = bvalid_q;
    S_AXI_BRESP  = bresp_q;
    S_AXI_RVALID = rvalid_q;
    S_AXI_RDATA  = rdata_q;
    S_AXI_RRESP  = rresp_q;
    reg_wr_pulse = pulse_q;
    reg_out      = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      reg_out[DW*k +: DW] = regs_q[k];
    end
  end

  // Write path: the held copy wins over the live bus once a channel has handshaken.
  always_comb begin : p_write_sel
    aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    commit    = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wr_idx    = aw_held_q ? aw_idx_q : S_AXI_AWADDR[AW-1:2];
    wr_beat   = w_held_q ? w_beat_q : wr_beat_t'{data: S_AXI_WDATA, strb: S_AXI_WSTRB};
    wr_mapped = 32'(wr_idx) < NUM_REGS;
  end

  always_comb begin : p_write_next
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_beat_d  = w_beat_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (wr_idx == IDX_W'(k)) begin
          pulse_d[k] = 1'b1;
          for (int b = 0; b < int'(SW); b++) begin
            if (wr_beat.strb[b]) begin
              regs_d[k][8*b +: 8] = wr_beat.data[8*b +: 8];
            end
          end
        end
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[AW-1:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_beat_d = wr_beat_t'{data: S_AXI_WDATA, strb: S_AXI_WSTRB};
      end
    end
  end

  // Read path samples regs_q, so a same-edge write is not yet visible.
  always_comb begin : p_read_next
    ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    rd_idx    = S_AXI_ARADDR[AW-1:2];
    rd_mapped = 32'(rd_idx) < NUM_REGS;
    rd_word   = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_word = regs_q[k];
      end
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin : p_state
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_beat_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pulse_q   <= '0;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_beat_q  <= w_beat_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cov_mean_axil_regs.sv
// Scoreboard bench for cov_mean_axil_regs; honours COV_MEAN_AXIL_SLVERR_EN for expected responses.
module tb_cov_mean_axil_regs;

  localparam int NR = 4;

  logic         aclk = 1'b0;
  logic         areset;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  always #5 aclk = ~aclk;

  cov_mean_axil_regs dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int b_seen   = 0;
  int r_seen   = 0;
  bit hold_bready = 1'b0;
  bit hold_rready = 1'b0;

  logic [31:0]   model [NR];
  logic [1:0]    exp_b_q [$];
  logic [33:0]   exp_r_q [$];
  logic [NR-1:0] exp_p_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [5:0] addr);
    logic [1:0] unmapped;
    unmapped = 2'b00;
`ifdef COV_MEAN_AXIL_SLVERR_EN
    unmapped = 2'b10;
`endif
    return (int'(addr[5:2]) < NR) ? 2'b00 : unmapped;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] model_packed();
    logic [127:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  // Ready drivers change just after the rising edge so negedge samples match the next edge.
  always @(posedge aclk) begin
    #1;
    bready = hold_bready ? 1'b0 : ($urandom_range(0, 3) != 0);
    rready = hold_rready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a completed response or pulse.
  logic       r_stalled = 1'b0;
  logic [34:0] r_prev;
  always @(negedge aclk) begin
    if (areset) begin
      r_stalled = 1'b0;
    end else begin
      if (bvalid && bready) begin
        b_seen++;
        if (exp_b_q.size() == 0) check("b_unexpected", 128'(1), 128'(0));
        else check("bresp", 128'(bresp), 128'(exp_b_q.pop_front()));
      end
      if (r_stalled) check("r_stable", 128'({rvalid, rresp, rdata}), 128'(r_prev));
      r_stalled = rvalid && !rready;
      r_prev    = {1'b1, rresp, rdata};
      if (rvalid && rready) begin
        r_seen++;
        if (exp_r_q.size() == 0) check("r_unexpected", 128'(1), 128'(0));
        else check("rresp_rdata", 128'({rresp, rdata}), 128'(exp_r_q.pop_front()));
      end
      if (reg_wr_pulse != '0) begin
        if (exp_p_q.size() == 0) check("pulse_unexpected", 128'(reg_wr_pulse), 128'(0));
        else check("reg_wr_pulse", 128'(reg_wr_pulse), 128'(exp_p_q.pop_front()));
      end
    end
  end

  // Call at a negedge; returns at a negedge with both channels idle.
  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lag, input int w_lag, input int b_stall);
    int aw_wait, w_wait, target, n;
    exp_b_q.push_back(exp_resp(addr));
    if (int'(addr[5:2]) < NR) begin
      exp_p_q.push_back(NR'(1) << addr[3:2]);
      model[addr[3:2]] = apply_strb(model[addr[3:2]], data, strb);
    end
    if (b_stall > 0) begin
      hold_bready = 1'b1;
      @(negedge aclk);
    end
    target = b_seen + 1;
    aw_wait = 0;
    w_wait  = 0;
    fork
      begin
        repeat (aw_lag) @(negedge aclk);
        awaddr = addr; awvalid = 1'b1;
        while (!awready && aw_wait < 50) begin @(negedge aclk); aw_wait++; end
        @(negedge aclk); awvalid = 1'b0;
      end
      begin
        repeat (w_lag) @(negedge aclk);
        wdata = data; wstrb = strb; wvalid = 1'b1;
        while (!wready && w_wait < 50) begin @(negedge aclk); w_wait++; end
        @(negedge aclk); wvalid = 1'b0;
      end
    join
    check("awready_wait", 128'(aw_wait), 128'(0));
    check("wready_wait", 128'(w_wait), 128'(0));
    check("bvalid_latency", 128'(bvalid), 128'(1));
    repeat (b_stall) begin
      check("bvalid_hold", 128'({bvalid, awready, wready}), 128'(3'b100));
      @(negedge aclk);
    end
    hold_bready = 1'b0;
    n = 0;
    while (b_seen < target && n < 100) begin @(negedge aclk); n++; end
    check("b_done", 128'(b_seen >= target), 128'(1));
    @(negedge aclk);
    check("reg_out", reg_out, model_packed());
  endtask

  task automatic do_read(input logic [5:0] addr);
    int ar_wait, target, n;
    logic [31:0] d;
    d = (int'(addr[5:2]) < NR) ? model[addr[3:2]] : 32'h0;
    exp_r_q.push_back({exp_resp(addr), d});
    target  = r_seen + 1;
    ar_wait = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && ar_wait < 50) begin @(negedge aclk); ar_wait++; end
    @(negedge aclk); arvalid = 1'b0;
    check("arready_wait", 128'(ar_wait), 128'(0));
    check("rvalid_latency", 128'(rvalid), 128'(1));
    n = 0;
    while (r_seen < target && n < 100) begin @(negedge aclk); n++; end
    check("r_done", 128'(r_seen >= target), 128'(1));
    @(negedge aclk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse}),
          128'(0));
    check({name, "_regs"}, reg_out, 128'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    areset = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    #1 areset = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // Basic write/read-back of every register
    for (int i = 0; i < NR; i++) do_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NR; i++) do_read(6'(4 * i));
    check("t1_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

    // Byte-lane merge
    do_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(6'h00, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(6'h00);
    check("t2_strb_merge", 128'(reg_out[31:0]), 128'(32'hAA22CC44));

    // AW well ahead of W, and W well ahead of AW
    do_write(6'h08, 32'h5A5A0001, 4'hF, 0, 3, 0);
    do_write(6'h0C, 32'h5A5A0002, 4'hF, 3, 0, 0);

    // Back-pressured B channel, then a normal write
    do_write(6'h04, 32'hCAFE0004, 4'hF, 0, 0, 5);
    do_write(6'h08, 32'hCAFE0008, 4'hF, 0, 0, 0);

    // Zero strobe still pulses; unaligned addresses map to the containing word
    do_write(6'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    do_write(6'h05, 32'h0BADF00D, 4'hF, 1, 0, 0);
    do_read(6'h07);

    // Unmapped offset
    do_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(6'h10);
    do_read(6'h3C);

    // Reset after AW handshake but before W
    awaddr = 6'h04; awvalid = 1'b1;
    w = 0;
    while (!awready && w < 50) begin @(negedge aclk); w++; end
    @(negedge aclk); awvalid = 1'b0;
    check("aw_held_blocks", 128'(awready), 128'(0));
    #2 areset = 1'b1;
    #1 check_all_zero("mid_reset");
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (5) begin
      @(negedge aclk);
      check("no_b_after_abort", 128'(bvalid), 128'(0));
    end
    do_write(6'h04, 32'h12345678, 4'hF, 0, 2, 0);
    do_read(6'h04);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(6'($urandom_range(0, 31)), $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 2 : 0);
      else
        do_read(6'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge aclk);
    check("b_queue_empty", 128'(exp_b_q.size()), 128'(0));
    check("r_queue_empty", 128'(exp_r_q.size()), 128'(0));
    check("pulse_queue_empty", 128'(exp_p_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
